fifo_ctrl: RTL and testbench

Pointer and flag controller for a synchronous single-clock FIFO whose storage is an external array of D flip-flops (DEPTH words).
- Accepts write/read requests and gates them into write/read enables.
- Generates the write and read addresses.
- Maintains occupancy, full/empty and threshold flags.
- Produces a registered read-valid strobe aligned with the storage's one-cycle read latency.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ctrl_if.sv | 41 ++++
 rtl/fifo_ptr.sv | 15 +
 rtl/fifo_ctrl.sv | 74 +++++++
 tb/tb_fifo_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, pointer type and pointer-compare helpers for fifo_ctrl.
// Helpers take zero-extended pointers plus the address width so any DEPTH can use them.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = 3;
  localparam int PTR_MAX    = 16;

  typedef logic [FIFO_AW:0] ptr_t;

  // Full: same slot, opposite lap (wrap bits differ).
  function automatic logic ptr_full(input logic [PTR_MAX-1:0] wr,
                                    input logic [PTR_MAX-1:0] rd,
                                    input int aw);
    logic [PTR_MAX-1:0] msk;
    msk = (PTR_MAX'(1) << aw) - PTR_MAX'(1);
    return ((wr & msk) == (rd & msk)) && (wr[aw] != rd[aw]);
  endfunction

  // Empty: same slot, same lap.
  function automatic logic ptr_empty(input logic [PTR_MAX-1:0] wr,
                                     input logic [PTR_MAX-1:0] rd);
    return wr == rd;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/enable/flag bundle between a FIFO requester and fifo_ctrl.
// Optional error flags exist only when FIFO_CTRL_ERR_EN is defined.
interface fifo_ctrl_if #(parameter int AW = 3);
  logic          wr_req;
  logic          rd_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
`ifdef FIFO_CTRL_ERR_EN
  logic          err_clr;
  logic          overflow;
  logic          underflow;
`endif

  modport master (
    output wr_req, rd_req,
`ifdef FIFO_CTRL_ERR_EN
    output err_clr,
    input  overflow, underflow,
`endif
    input  wr_en, wr_addr, rd_en, rd_addr, rd_valid,
    input  full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  wr_req, rd_req,
`ifdef FIFO_CTRL_ERR_EN
    input  err_clr,
    output overflow, underflow,
`endif
    output wr_en, wr_addr, rd_en, rd_addr, rd_valid,
    output full, empty, almost_full, almost_empty, count
  );
endinterface

// File: rtl/fifo_ptr.sv
// Wrap-counting FIFO pointer: W bits, MSB is the lap bit, sync active-low reset.
module fifo_ptr #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Advance by one on each accepted op; wraps modulo 2^W.
  always_ff @(posedge clk) begin
    if (!rst)     ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a single-clock FIFO with external DFF storage.
// Flags and count are decoded from the registered pointers only.
// Optional sticky overflow/underflow flags: define FIFO_CTRL_ERR_EN.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AW       = FIFO_AW,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic        clk,
  input  logic        rst,
  fifo_ctrl_if.slave  bus
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fifo_ctrl: DEPTH must be a power of 2, >= 2");
  end
  if (AW != $clog2(DEPTH)) begin : g_bad_aw
    $fatal(1, "fifo_ctrl: AW must equal log2(DEPTH)");
  end

  logic [AW:0] wr_ptr, rd_ptr, cnt;
  logic        wr_en, rd_en, full, empty, rd_vld_q;

  assign full  = ptr_full(PTR_MAX'(wr_ptr), PTR_MAX'(rd_ptr), AW);
  assign empty = ptr_empty(PTR_MAX'(wr_ptr), PTR_MAX'(rd_ptr));
  assign wr_en = bus.wr_req & ~full;
  assign rd_en = bus.rd_req & ~empty;
  // Lap bit makes the modular difference span 0..DEPTH without ambiguity.
  assign cnt   = wr_ptr - rd_ptr;

  fifo_ptr #(.W(AW + 1)) u_wr_ptr (.clk(clk), .rst(rst), .inc(wr_en), .ptr(wr_ptr));
  fifo_ptr #(.W(AW + 1)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_en), .ptr(rd_ptr));

  // Storage has one cycle of read latency; mark its data valid a cycle after rd_en.
  always_ff @(posedge clk) begin
    if (!rst) rd_vld_q <= 1'b0;
    else      rd_vld_q <= rd_en;
  end

  assign bus.wr_en        = wr_en;
  assign bus.rd_en        = rd_en;
  assign bus.wr_addr      = wr_ptr[AW-1:0];
  assign bus.rd_addr      = rd_ptr[AW-1:0];
  assign bus.rd_valid     = rd_vld_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = cnt;
  assign bus.almost_full  = cnt >= (AW + 1)'(AF_LEVEL);
  assign bus.almost_empty = cnt <= (AW + 1)'(AE_LEVEL);

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, unf_q;

  // Sticky error flags; a new drop in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_req & full)       ovf_q <= 1'b1;
      else if (bus.err_clr)        ovf_q <= 1'b0;
      if (bus.rd_req & empty)      unf_q <= 1'b1;
      else if (bus.err_clr)        unf_q <= 1'b0;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (DEPTH=8, AF=6, AE=2): directed phases plus
// random traffic against an occupancy/index model.
module tb_fifo_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.AW(AW)) bus ();

  fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int vectors = 0;
  int errs    = 0;

  // Reference model: occupancy plus free-running write/read op counts.
  int m_cnt = 0, m_wn = 0, m_rn = 0;
  bit m_rv = 0, m_ov = 0, m_un = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wn = 0; m_rn = 0; m_rv = 0; m_ov = 0; m_un = 0;
  endtask

  // One cycle: drive at negedge, check everything, then advance the model on posedge.
  task automatic step(input bit w, input bit r);
    bit we, re;
    bus.wr_req = w;
    bus.rd_req = r;
`ifdef FIFO_CTRL_ERR_EN
    bus.err_clr = clr;
`endif
    #1;
    we = w && (m_cnt < DEPTH);
    re = r && (m_cnt > 0);
    chk("wr_en",        32'(bus.wr_en),        32'(we));
    chk("rd_en",        32'(bus.rd_en),        32'(re));
    chk("wr_addr",      32'(bus.wr_addr),      32'(m_wn % DEPTH));
    chk("rd_addr",      32'(bus.rd_addr),      32'(m_rn % DEPTH));
    chk("count",        32'(bus.count),        32'(m_cnt));
    chk("full",         32'(bus.full),         32'(m_cnt == DEPTH));
    chk("empty",        32'(bus.empty),        32'(m_cnt == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(m_cnt >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= AE));
    chk("rd_valid",     32'(bus.rd_valid),     32'(m_rv));
`ifdef FIFO_CTRL_ERR_EN
    chk("overflow",     32'(bus.overflow),     32'(m_ov));
    chk("underflow",    32'(bus.underflow),    32'(m_un));
`endif
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (w && m_cnt == DEPTH) m_ov = 1; else if (clr) m_ov = 0;
      if (r && m_cnt == 0)     m_un = 1; else if (clr) m_un = 0;
      m_wn  = (m_wn + int'(we)) % (2 * DEPTH);
      m_rn  = (m_rn + int'(re)) % (2 * DEPTH);
      m_cnt = m_cnt + int'(we) - int'(re);
      m_rv  = re;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
    bus.err_clr = 1'b0;
`endif
    // Reset for two clocks, then idle.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    step(0, 0);

    // Fill with one extra write, drain with one extra read.
    repeat (DEPTH + 1) step(1, 0);
    repeat (DEPTH + 1) step(0, 1);

    // Simultaneous at empty, at 4, at full.
    step(1, 1);
    repeat (3) step(1, 0);
    repeat (2) step(1, 1);
    repeat (4) step(1, 0);
    step(1, 1);
    step(0, 0);

    // Drain, then interleaved writes/reads across the wrap.
    repeat (DEPTH) step(0, 1);
    repeat (12) begin step(1, 0); step(0, 1); end

    // Randomized traffic with occasional resets.
    repeat (300) begin
      rst = ($urandom_range(0, 31) != 0);
      clr = ($urandom_range(0, 7) == 0);
      step(1'($urandom), 1'($urandom));
    end
    rst = 1'b1;
    clr = 1'b0;

    // Reset mid-operation at count 5.
    repeat (DEPTH) step(0, 1);
    repeat (5) step(1, 0);
    rst = 1'b0;
    step(0, 0);
    rst = 1'b1;
    step(0, 0);

`ifdef FIFO_CTRL_ERR_EN
    // Overflow set, cleared, then clear racing a new overflow.
    repeat (DEPTH) step(1, 0);
    step(1, 0);
    step(0, 0);
    clr = 1'b1;
    step(0, 0);
    step(1, 0);
    clr = 1'b0;
    step(0, 0);
    // Underflow set and clear.
    repeat (DEPTH) step(0, 1);
    step(0, 1);
    step(0, 0);
    clr = 1'b1;
    step(0, 0);
    clr = 1'b0;
    step(0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
